// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NREQ
// byte producers, with packet locking and a stuck-transmitter timeout.
// Handshake: a byte of requester i moves on a rising clk edge when
// req_valid[i] & req_ready[i]; req_ready is one-hot and only offered in IDLE.
module uart_tx_arbiter #(
   parameter int NREQ           = 4,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*DATA_W-1:0]     req_data,
   input  logic [NREQ-1:0]            req_lock,
   output logic [NREQ-1:0]            req_ready,
   input  logic                       tx_busy,
   output logic                       tx_start,
   output logic [DATA_W-1:0]          tx_data,
   output logic [$clog2(NREQ)-1:0]    grant_id,
   output logic                       active,
   output logic                       timeout_err,
   input  logic                       err_clr,
   output logic [1:0]                 state_dbg
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                busy_m_q, busy_s_q;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]       lock_owner_q, lock_owner_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic                lock_hold_q, lock_hold_d;
   logic                tx_start_q, tx_start_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NREQ-1:0]     cand;
   logic [GW-1:0]       win;
   logic [DATA_W-1:0]   win_data;
   logic                found, take, timeout;
   int                  scan, nxt;

   // Two-flop synchronizer for the baud-domain busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_m_q <= 1'b0;
         busy_s_q <= 1'b0;
      end else begin
         busy_m_q <= tx_busy;
         busy_s_q <= busy_m_q;
      end
   end

   // Winner search upward from rr_ptr, restricted to the owner while locked
   always_comb begin
      cand = req_valid;
      if (lock_hold_q) cand = req_valid & (NREQ'(1) << lock_owner_q);
      found    = 1'b0;
      win      = '0;
      scan     = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan = int'(rr_ptr_q) + k;
         if (scan >= NREQ) scan = scan - NREQ;
         if (!found && cand[GW'(scan)]) begin
            found = 1'b1;
            win   = GW'(scan);
         end
      end
      win_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == GW'(k)) win_data = req_data[k*DATA_W +: DATA_W];
      end
      nxt = int'(win) + 1;
      if (nxt >= NREQ) nxt = 0;
   end

   assign take    = |(req_valid & req_ready);
   assign timeout = (state_q != S_IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic; timeout has priority over busy progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (take) state_d = S_START;
         S_START: if (timeout) state_d = S_IDLE;
                  else if (busy_s_q) state_d = S_WAIT;
         S_WAIT:  if (timeout || !busy_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: handshake offer is combinational and masked during reset
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && found && !rst) req_ready = NREQ'(1) << win;
      active    = (state_q != S_IDLE);
      state_dbg = state_q;
   end

   // Datapath next values: capture on accept, counter, lock and error flag
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_owner_d = lock_owner_q;
      lock_hold_d  = lock_hold_q;
      grant_d      = grant_q;
      data_d       = data_q;
      tx_start_d   = tx_start_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               data_d      = win_data;
               grant_d     = win;
               tx_start_d  = 1'b1;
               cnt_d       = '0;
               rr_ptr_d    = GW'(nxt);
               lock_hold_d = req_lock[win];
               if (req_lock[win]) lock_owner_d = win;
            end
         end
         S_START: begin
            if (timeout) begin
               tx_start_d  = 1'b0;
               lock_hold_d = 1'b0;
            end else if (busy_s_q) begin
               tx_start_d = 1'b0;
               cnt_d      = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (timeout) lock_hold_d = 1'b0;
            else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
         default: ;
      endcase
      if (timeout)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
      else              err_d = err_q;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         lock_owner_q <= '0;
         lock_hold_q  <= 1'b0;
         grant_q      <= '0;
         data_q       <= '0;
         tx_start_q   <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_owner_q <= lock_owner_d;
         lock_hold_q  <= lock_hold_d;
         grant_q      <= grant_d;
         data_q       <= data_d;
         tx_start_q   <= tx_start_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_data     = data_q;
   assign grant_id    = grant_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, reset mid-byte,
// round robin, packet lock, timeout with lock, and err_clr/timeout collision.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int TO   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   req_lock;
   logic [NREQ-1:0]   req_ready;
   logic              tx_busy;
   logic              tx_start;
   logic [DW-1:0]     tx_data;
   logic [1:0]        grant_id;
   logic              active;
   logic              timeout_err;
   logic              err_clr;
   logic [1:0]        state_dbg;

   int checks   = 0;
   int failures = 0;

   uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_lock    (req_lock),
      .req_ready   (req_ready),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err),
      .err_clr     (err_clr),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Called at the first negedge after an accept; models a busy pulse
   // raised immediately and held for 7 cycles, then checks the return to IDLE.
   task automatic serve(input logic [1:0] id, input logic [7:0] d);
      chk("start_hi", 32'(tx_start), 32'd1);
      chk("active_hi", 32'(active), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(id));
      chk("tx_data", 32'(tx_data), 32'(d));
      chk("ready_start", 32'(req_ready), 32'd0);
      tx_busy = 1'b1;
      tick; tick;
      chk("start_held", 32'(tx_start), 32'd1);
      tick;
      chk("start_drop", 32'(tx_start), 32'd0);
      chk("state_wait", 32'(state_dbg), 32'd2);
      repeat (4) tick;
      tx_busy = 1'b0;
      tick; tick;
      chk("still_wait", 32'(state_dbg), 32'd2);
      chk("data_stable", 32'(tx_data), 32'(d));
      tick;
      chk("back_idle", 32'(state_dbg), 32'd0);
      chk("active_lo", 32'(active), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 4'hF; req_data = '0; req_lock = '0;
      tx_busy = 1'b0; err_clr = 1'b0;
      tick; tick;
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      req_valid = '0; rst = 1'b0;
      tick;

      // single requester
      req_data = 32'h00A5_0000; req_valid = 4'b0100;
      #1 chk("single_ready", 32'(req_ready), 32'h4);
      tick;
      req_valid = '0;
      serve(2'd2, 8'hA5);

      // reset in WAIT
      req_data = 32'h0000_5A00; req_valid = 4'b0010;
      #1 chk("mid_ready", 32'(req_ready), 32'h2);
      tick;
      req_valid = '0; tx_busy = 1'b1;
      tick; tick; tick;
      chk("mid_wait", 32'(state_dbg), 32'd2);
      req_valid = 4'hF; rst = 1'b1;
      #1;
      chk("mid_rst_start", 32'(tx_start), 32'd0);
      chk("mid_rst_active", 32'(active), 32'd0);
      chk("mid_rst_state", 32'(state_dbg), 32'd0);
      chk("mid_rst_grant", 32'(grant_id), 32'd0);
      chk("mid_rst_data", 32'(tx_data), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      tx_busy = 1'b0;
      tick; tick;
      rst = 1'b0;
      #1 chk("rr_ptr_zero", 32'(req_ready), 32'h1);
      req_valid = 4'b1000; req_data = 32'h3C00_0000;
      #1 chk("post_rst_ready", 32'(req_ready), 32'h8);
      tick;
      req_valid = '0;
      serve(2'd3, 8'h3C);

      // round robin, all valid
      req_data = 32'h1312_1110; req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1 chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
         chk("rr_onehot", 32'($countones(req_ready)), 32'd1);
         tick;
         serve(2'(i % 4), 8'(8'h10 + (i % 4)));
      end
      req_valid = '0;

      // lock: requester 1 sends three bytes, requester 0 waits
      req_data = 32'h0000_3120; req_valid = 4'b0011; req_lock = 4'b0010;
      #1 chk("lock_ready1", 32'(req_ready), 32'h2);
      tick;
      serve(2'd1, 8'h31);
      req_valid = 4'b0001;
      #1 chk("lock_starve", 32'(req_ready), 32'h0);
      tick;
      chk("lock_starve2", 32'(req_ready), 32'h0);
      chk("lock_idle", 32'(state_dbg), 32'd0);
      req_valid = 4'b0011; req_data = 32'h0000_3220;
      #1 chk("lock_ready2", 32'(req_ready), 32'h2);
      tick;
      serve(2'd1, 8'h32);
      req_data = 32'h0000_3320; req_lock = 4'b0000;
      #1 chk("lock_ready3", 32'(req_ready), 32'h2);
      tick;
      serve(2'd1, 8'h33);
      #1 chk("lock_release", 32'(req_ready), 32'h1);
      tick;
      req_valid = '0;
      serve(2'd0, 8'h20);

      // timeout while holding a lock
      req_data = 32'h0077_0020; req_valid = 4'b0100; req_lock = 4'b0100;
      #1 chk("to_ready", 32'(req_ready), 32'h4);
      tick;
      req_valid = 4'b0101; req_lock = '0;
      repeat (15) tick;
      chk("to_pre_start", 32'(tx_start), 32'd1);
      chk("to_pre_state", 32'(state_dbg), 32'd1);
      chk("to_pre_err", 32'(timeout_err), 32'd0);
      tick;
      chk("to_start", 32'(tx_start), 32'd0);
      chk("to_err", 32'(timeout_err), 32'd1);
      chk("to_state", 32'(state_dbg), 32'd0);
      chk("to_grant_kept", 32'(grant_id), 32'd2);
      chk("to_data_kept", 32'(tx_data), 32'h77);
      #1 chk("to_lock_freed", 32'(req_ready), 32'h1);
      err_clr = 1'b1;
      tick;
      chk("err_cleared", 32'(timeout_err), 32'd0);
      err_clr = 1'b0; req_valid = '0;
      serve(2'd0, 8'h20);

      // timeout and err_clr in the same cycle: set wins
      req_data = 32'h9900_0000; req_valid = 4'b1000;
      #1 chk("sw_ready", 32'(req_ready), 32'h8);
      tick;
      req_valid = '0;
      repeat (15) tick;
      err_clr = 1'b1;
      tick;
      chk("set_wins", 32'(timeout_err), 32'd1);
      chk("sw_state", 32'(state_dbg), 32'd0);
      err_clr = 1'b0;
      tick;
      chk("err_sticky", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      tick;
      chk("err_clr2", 32'(timeout_err), 32'd0);
      err_clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
